// File: rtl/or_operand_fetch_pkg.sv
// Shared constants and types for the OR operand-fetch stage and its register file.
package or_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/or_operand_fetch_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, async clear.
// Register 0 is hard-wired to zero on read and ignores writes.
module or_regfile #(
  parameter int DATA_W   = or_pkg::DATA_W,
  parameter int ADDR_W   = or_pkg::ADDR_W,
  parameter int NUM_REGS = or_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
endmodule

// File: rtl/or_operand_fetch.sv
// Operand-fetch stage for the OR unit: register file read, busy scoreboard, one-entry output register.
// Optional same-cycle write-back forwarding is enabled by defining OR_OPERAND_FETCH_BYPASS_EN.
module or_operand_fetch #(
  parameter int DATA_W   = or_pkg::DATA_W,
  parameter int ADDR_W   = or_pkg::ADDR_W,
  parameter int NUM_REGS = or_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [ADDR_W-1:0]   iss_rs,
  input  logic [ADDR_W-1:0]   iss_rt,
  input  logic [ADDR_W-1:0]   iss_rd,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [DATA_W-1:0]   op_rs,
  output logic [DATA_W-1:0]   op_rt,
  output logic [ADDR_W-1:0]   op_rd,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic [NUM_REGS-1:0] busy_vec
);
  // Handshake: a transfer happens on any rising edge where valid && ready; ready never
  // looks at valid, and the producer holds its payload stable while valid && !ready.

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_eff;
  logic [NUM_REGS-1:0] busy_n;
  logic [DATA_W-1:0]   rf_rs;
  logic [DATA_W-1:0]   rf_rt;
  logic [DATA_W-1:0]   rs_val;
  logic [DATA_W-1:0]   rt_val;
  logic                hazard;
  logic                accept;

  or_regfile #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr_a(iss_rs),
    .rdata_a(rf_rs),
    .raddr_b(iss_rt),
    .rdata_b(rf_rt),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  // Busy view used for the hazard check; with forwarding, a same-cycle write-back retires its tag.
  always_comb begin
    busy_eff = busy_q;
`ifdef OR_OPERAND_FETCH_BYPASS_EN
    if (wb_en) busy_eff[wb_addr] = 1'b0;
`endif
  end

  always_comb begin
    rs_val = rf_rs;
    rt_val = rf_rt;
`ifdef OR_OPERAND_FETCH_BYPASS_EN
    if (wb_en && wb_addr != or_pkg::ZERO_REG && wb_addr == iss_rs) rs_val = wb_data;
    if (wb_en && wb_addr != or_pkg::ZERO_REG && wb_addr == iss_rt) rt_val = wb_data;
`endif
  end

  assign hazard    = busy_eff[iss_rs] | busy_eff[iss_rt] | busy_eff[iss_rd];
  assign iss_ready = !hazard && (!op_valid || op_ready);
  assign accept    = iss_valid && iss_ready;
  assign busy_vec  = busy_q;

  // A new issue claiming a register wins over a write-back retiring the same register.
  always_comb begin
    busy_n = busy_q;
    if (wb_en) busy_n[wb_addr] = 1'b0;
    if (accept) busy_n[iss_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      op_valid <= 1'b0;
      op_rs    <= '0;
      op_rt    <= '0;
      op_rd    <= '0;
    end else begin
      busy_q <= busy_n;
      if (accept) begin
        op_valid <= 1'b1;
        op_rs    <= rs_val;
        op_rt    <= rt_val;
        op_rd    <= iss_rd;
      end else if (op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end
endmodule
